// File: rtl/code_lock_fsm.sv
// Multi-digit code lock: digit entry, code reprogramming while open, failure counting with blinking alarm.
// Optional timed lockout after MAX_TRIES failures is built when LOCKOUT_EN is defined.
//
// state     | meaning
// IDLE      | waiting for first digit
// ENTRY     | collecting code digits, mismatch tracked
// OPEN      | correct code entered, lock released
// ALARM     | MAX_TRIES failures, waits for cancel
// SET_ENTRY | collecting new code into shadow
// LOCKOUT   | timed lockout, all inputs ignored
module code_lock_fsm #(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 4,
    parameter int MAX_TRIES      = 3,
    parameter logic [DIGIT_W*CODE_LEN-1:0] RESET_CODE = 16'h1234,
    parameter int BLINK_DIV      = 8,
    parameter int LOCKOUT_CYCLES = 1024,
    localparam int FW = $clog2(MAX_TRIES+1),
    localparam int IW = $clog2(CODE_LEN+1)
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] digit_in_i,
    input  logic               enter_i,
    input  logic               set_btn_i,
    input  logic               cancel_i,
    output logic               unlocked_o,
    output logic               alarm_led_o,
    output logic               fail_pulse_o,
    output logic [2:0]         state_o,
    output logic [FW-1:0]      fail_cnt_o,
    output logic [IW-1:0]      entry_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ENTRY     = 3'd1,
        S_OPEN      = 3'd2,
        S_ALARM     = 3'd3,
        S_SET_ENTRY = 3'd4,
        S_LOCKOUT   = 3'd5
    } state_t;

    if (CODE_LEN < 1 || MAX_TRIES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_param
        $error("code_lock_fsm: CODE_LEN, MAX_TRIES and LOCKOUT_CYCLES must be >= 1");
    end

    state_t                            state_q, state_d;
    logic [CODE_LEN-1:0][DIGIT_W-1:0]  code_q, code_d;
    logic [CODE_LEN-1:0][DIGIT_W-1:0]  shadow_q, shadow_d;
    logic [FW-1:0]                     fail_q, fail_d;
    logic [IW-1:0]                     idx_q, idx_d;
    logic                              mis_q, mis_d;
    logic                              pulse_q, pulse_d;
    logic [BLINK_DIV:0]                blink_q;
    logic [DIGIT_W-1:0]                digit_q;
    logic                              enter_q, enter_prev_q;
    logic                              set_q, set_prev_q;
    logic                              cancel_q, cancel_prev_q;
    logic                              enter_rise, set_rise, cancel_rise;
    logic [DIGIT_W-1:0]                exp_digit;
    logic                              mis_now;
    logic [FW-1:0]                     fail_inc;
`ifdef LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES+1);
    logic [LW-1:0]                     lock_cnt_q, lock_cnt_d;
`endif

    assign enter_rise  = enter_q  & ~enter_prev_q;
    assign set_rise    = set_q    & ~set_prev_q;
    assign cancel_rise = cancel_q & ~cancel_prev_q;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        shadow_d  = shadow_q;
        fail_d    = fail_q;
        idx_d     = idx_q;
        mis_d     = mis_q;
        pulse_d   = 1'b0;
        exp_digit = '0;
`ifdef LOCKOUT_EN
        lock_cnt_d = lock_cnt_q;
`endif
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx_q == IW'(i)) exp_digit = code_q[i];
        end
        mis_now  = mis_q | (digit_q != exp_digit);
        fail_inc = fail_q + 1'b1;

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (cancel_rise) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                end else if (enter_rise) begin
                    if (idx_q == IW'(CODE_LEN-1)) begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (!mis_now) begin
                            state_d = S_OPEN;
                            fail_d  = '0;
                        end else begin
                            pulse_d = 1'b1;
                            fail_d  = fail_inc;
                            if (fail_inc == FW'(MAX_TRIES)) begin
`ifdef LOCKOUT_EN
                                state_d    = S_LOCKOUT;
                                lock_cnt_d = LW'(LOCKOUT_CYCLES);
`else
                                state_d = S_ALARM;
`endif
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        state_d = S_ENTRY;
                        idx_d   = idx_q + 1'b1;
                        mis_d   = mis_now;
                    end
                end
            end
            S_OPEN: begin
                if (cancel_rise) begin
                    state_d = S_IDLE;
                end else if (set_rise) begin
                    state_d = S_SET_ENTRY;
                    idx_d   = '0;
                end else if (enter_rise) begin
                    state_d = S_IDLE;
                end
            end
            S_SET_ENTRY: begin
                if (cancel_rise) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (enter_rise) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (idx_q == IW'(i)) shadow_d[i] = digit_q;
                    end
                    if (idx_q == IW'(CODE_LEN-1)) begin
                        code_d  = shadow_d;
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_ALARM: begin
                if (cancel_rise) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end
            end
`ifdef LOCKOUT_EN
            // counter was loaded with the full duration; leaving as it hits 0
            S_LOCKOUT: begin
                lock_cnt_d = lock_cnt_q - 1'b1;
                if (lock_cnt_q == LW'(1)) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                mis_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            code_q        <= RESET_CODE;
            shadow_q      <= '0;
            fail_q        <= '0;
            idx_q         <= '0;
            mis_q         <= 1'b0;
            pulse_q       <= 1'b0;
            blink_q       <= '0;
            digit_q       <= '0;
            enter_q       <= 1'b0;
            enter_prev_q  <= 1'b0;
            set_q         <= 1'b0;
            set_prev_q    <= 1'b0;
            cancel_q      <= 1'b0;
            cancel_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            shadow_q      <= shadow_d;
            fail_q        <= fail_d;
            idx_q         <= idx_d;
            mis_q         <= mis_d;
            pulse_q       <= pulse_d;
            blink_q       <= blink_q + 1'b1;
            digit_q       <= digit_in_i;
            enter_q       <= enter_i;
            enter_prev_q  <= enter_q;
            set_q         <= set_btn_i;
            set_prev_q    <= set_q;
            cancel_q      <= cancel_i;
            cancel_prev_q <= cancel_q;
        end
    end

`ifdef LOCKOUT_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) lock_cnt_q <= '0;
        else        lock_cnt_q <= lock_cnt_d;
    end
`endif

    assign unlocked_o   = (state_q == S_OPEN);
    assign alarm_led_o  = ((state_q == S_ALARM) || (state_q == S_LOCKOUT)) && blink_q[BLINK_DIV];
    assign fail_pulse_o = pulse_q;
    assign state_o      = state_q;
    assign fail_cnt_o   = fail_q;
    assign entry_idx_o  = idx_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed bench for code_lock_fsm with default parameters; covers the LOCKOUT_EN build as well.
module tb_code_lock_fsm;

    logic       clk_i = 1'b0;
    logic       rst_n;
    logic [3:0] digit_in_i;
    logic       enter_i, set_btn_i, cancel_i;
    logic       unlocked_o, alarm_led_o, fail_pulse_o;
    logic [2:0] state_o;
    logic [1:0] fail_cnt_o;
    logic [2:0] entry_idx_o;

    int checks = 0;
    int errors = 0;

    code_lock_fsm dut (
        .clk_i(clk_i), .rst_n(rst_n), .digit_in_i(digit_in_i), .enter_i(enter_i),
        .set_btn_i(set_btn_i), .cancel_i(cancel_i), .unlocked_o(unlocked_o),
        .alarm_led_o(alarm_led_o), .fail_pulse_o(fail_pulse_o), .state_o(state_o),
        .fail_cnt_o(fail_cnt_o), .entry_idx_o(entry_idx_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        digit_in_i = d; enter_i = 1'b1;
        @(negedge clk_i); enter_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic press_code(input logic [3:0] d0, d1, d2, d3);
        press(d0); press(d1); press(d2); press(d3);
    endtask

    task automatic press_set();
        set_btn_i = 1'b1; @(negedge clk_i); set_btn_i = 1'b0; @(negedge clk_i);
    endtask

    task automatic press_cancel();
        cancel_i = 1'b1; @(negedge clk_i); cancel_i = 1'b0; @(negedge clk_i);
    endtask

    int n;
    logic v;

    initial begin
        rst_n = 1'b0; digit_in_i = '0; enter_i = 0; set_btn_i = 0; cancel_i = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_state", state_o, 0);
        chk("rst_outs", {unlocked_o, alarm_led_o, fail_pulse_o}, 0);
        chk("rst_cnts", {fail_cnt_o, entry_idx_o}, 0);
        rst_n = 1'b1;
        @(negedge clk_i);

        // correct code, digit 0 first
        press(4);
        chk("entry_state", state_o, 1);
        chk("entry_idx1", entry_idx_o, 1);
        press(3); press(2);
        chk("entry_idx3", entry_idx_o, 3);
        press(1);
        chk("open_unlocked", unlocked_o, 1);
        chk("open_state", state_o, 2);
        chk("open_fail", fail_cnt_o, 0);
        chk("open_idx", entry_idx_o, 0);
        press_cancel();
        chk("open_cancel", {state_o, unlocked_o}, 0);

        // three failures
        press_code(4, 3, 2, 0);
        chk("fail1_state", state_o, 0);
        chk("fail1_pulse", fail_pulse_o, 1);
        chk("fail1_cnt", fail_cnt_o, 1);
        @(negedge clk_i);
        chk("fail1_pulse_end", fail_pulse_o, 0);
        press_code(5, 5, 5, 5);
        chk("fail2_cnt", fail_cnt_o, 2);
        chk("fail2_state", state_o, 0);
        press_code(4, 3, 2, 0);
`ifdef LOCKOUT_EN
        chk("lockout_state", state_o, 5);
        cancel_i = 1'b1; @(negedge clk_i); cancel_i = 1'b0;
        n = 1;
        while (state_o !== 3'd0 && n < 2000) begin @(negedge clk_i); n++; end
        chk("lockout_cycles", n, 1024);
        chk("lockout_fail_clr", fail_cnt_o, 0);
`else
        chk("alarm_state", state_o, 3);
        chk("alarm_cnt", fail_cnt_o, 3);
        v = alarm_led_o; n = 0;
        while (alarm_led_o === v && n < 600) begin @(negedge clk_i); n++; end
        chk("blink_edge_found", (n < 600), 1);
        for (int k = 0; k < 2; k++) begin
            v = alarm_led_o; n = 0;
            while (alarm_led_o === v && n < 600) begin @(negedge clk_i); n++; end
            chk("blink_half", n, 256);
        end
        press_code(4, 3, 2, 1);
        press_set();
        chk("alarm_ignores", state_o, 3);
        press_cancel();
        chk("alarm_ack_state", state_o, 0);
        chk("alarm_ack_cnt", fail_cnt_o, 0);
        chk("alarm_ack_led", alarm_led_o, 0);
`endif

        // reprogram to 9999
        press_code(4, 3, 2, 1);
        press_set();
        chk("set_state", state_o, 4);
        chk("set_idx", entry_idx_o, 0);
        press_code(9, 9, 9, 9);
        chk("set_done", {state_o, entry_idx_o}, 0);
        press_code(4, 3, 2, 1);
        chk("old_code_fails", {state_o, fail_cnt_o, fail_pulse_o}, {3'd0, 2'd1, 1'b1});
        press_code(9, 9, 9, 9);
        chk("new_code_opens", {state_o, fail_cnt_o, unlocked_o}, {3'd2, 2'd0, 1'b1});

        // cancelled reprogramming keeps 9999
        press_set();
        press(1); press(2);
        chk("set_partial_idx", entry_idx_o, 2);
        press_cancel();
        chk("set_cancel_state", state_o, 0);
        press_code(9, 9, 9, 9);
        chk("set_cancel_keeps", state_o, 2);

        // reset mid-programming restores RESET_CODE
        press_set();
        press(5); press(5);
        rst_n = 1'b0; #1;
        chk("midrst_outs", {state_o, unlocked_o, alarm_led_o, fail_pulse_o, fail_cnt_o, entry_idx_o}, 0);
        @(negedge clk_i); rst_n = 1'b1; @(negedge clk_i);
        press_code(4, 3, 2, 1);
        chk("midrst_code", state_o, 2);
        press(0);
        chk("open_enter_idle", state_o, 0);

        press_set();
        chk("set_ignored_idle", state_o, 0);

        // held enter counts once; cancel beats simultaneous enter
        digit_in_i = 4; enter_i = 1'b1;
        repeat (20) @(negedge clk_i);
        enter_i = 1'b0; @(negedge clk_i);
        chk("hold_idx", entry_idx_o, 1);
        chk("hold_state", state_o, 1);
        digit_in_i = 3; enter_i = 1'b1; cancel_i = 1'b1;
        @(negedge clk_i); enter_i = 1'b0; cancel_i = 1'b0;
        @(negedge clk_i);
        chk("cancel_prio", {state_o, entry_idx_o, fail_cnt_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_lock_fsm.md
# code_lock_fsm

Parametrised multi-digit code lock controller, the successor to the single-entry password lock on the top-level pin wrapper. It accepts a CODE_LEN-digit code one digit at a time and can reprogram the code while unlocked. It counts consecutive failed attempts and raises a blinking alarm after MAX_TRIES failures. It is fully synchronous to clk: button inputs are edge-detected internally, never used as clocks. It sits between the pin wrapper's input buses and its LED/status outputs.

## Interface
- DIGIT_W, 4: bits per digit.
- CODE_LEN, 4: digits per code (≥1).
- MAX_TRIES, 3: consecutive failures that trigger alarm/lockout (≥1).
- RESET_CODE, 16'h1234: code after reset, width DIGIT_W*CODE_LEN; digit 0 = LSBs, entered first.
- BLINK_DIV, 8: blink output = bit BLINK_DIV of free-running counter.
- LOCKOUT_CYCLES, 1024: lockout duration (LOCKOUT_EN only).

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- digit_in  in  DIGIT_W  digit value, sampled on enter rise.
- enter  in  1  enter button, synchronous level.
- set_btn  in  1  program-code request, synchronous level.
- cancel  in  1  abort / alarm acknowledge, synchronous level.
- unlocked  out  1  high in OPEN.
- alarm_led  out  1  blink bit in ALARM/LOCKOUT, else 0.
- fail_pulse  out  1  one-cycle pulse per failed attempt.
- state  out  3  current state encoding.
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures.
- entry_idx  out  $clog2(CODE_LEN+1)  digits accepted in current entry.

## Operation
- States: IDLE=0, ENTRY=1, OPEN=2, ALARM=3, SET_ENTRY=4, LOCKOUT=5; 6–7 illegal, recover to IDLE.
- Rise = input registered high this cycle, low the previous cycle. Priority on simultaneous rises: cancel > set_btn > enter.
- IDLE/ENTRY, enter rise: compare digit_in with code digit entry_idx, OR any mismatch into a sticky flag, entry_idx++, state ENTRY.
  - On the CODE_LEN-th digit: no mismatch → OPEN, fail_cnt=0. Mismatch → fail_pulse, fail_cnt++.
  - If the new fail_cnt equals MAX_TRIES → ALARM (LOCKOUT if LOCKOUT_EN); otherwise → IDLE.
  - entry_idx and the mismatch flag clear on every exit from ENTRY.
- ENTRY, cancel rise → IDLE; fail_cnt unchanged.
- OPEN: set_btn rise → SET_ENTRY, entry_idx=0. Enter or cancel rise → IDLE.
- SET_ENTRY, enter rise: digit_in stored into shadow slot entry_idx, entry_idx++. After the CODE_LEN-th digit, the shadow is copied to the code register in one cycle → IDLE. Cancel rise → IDLE, code unchanged.
- ALARM: cancel rise → IDLE, fail_cnt=0. Enter and set_btn are ignored.
- set_btn is ignored outside OPEN.
- Blink counter: BLINK_DIV+1 bits, free-running from reset, never cleared by state changes.
- Reset: state=IDLE, code=RESET_CODE, shadow=0, fail_cnt=0, entry_idx=0, mismatch flag=0, blink counter=0. All outputs 0.
- Reset during SET_ENTRY restores RESET_CODE; a partially entered code is never committed.

## Timing
- Inputs are registered once, then edge-detected. A rise first sampled at edge k updates the state and all outputs at edge k+1. Outputs are registered.
- Holding a button high produces exactly one action. A press needs one sampled low before the next rise.
- Presses on consecutive-rise cycles (high, low, high) are each accepted.
- fail_pulse is high for exactly the cycle that follows the failing digit's action edge.
- Blink period is 2^(BLINK_DIV+1) cycles with a 50% duty cycle.
- Code commit and unlock decision have no extra latency beyond the one cycle above.

## Configuration
- LOCKOUT_EN defined:
  - The MAX_TRIES-th failure enters LOCKOUT and loads a down-counter with LOCKOUT_CYCLES.
  - All inputs, including cancel, are ignored. alarm_led blinks.
  - When the counter reaches 0 → IDLE with fail_cnt=0. Residence is exactly LOCKOUT_CYCLES cycles.
- LOCKOUT_EN undefined: no counter logic is built, encoding 5 is unreachable, and the MAX_TRIES-th failure enters ALARM.

## Test plan
- Reset, then enter 4,3,2,1 (RESET_CODE=16'h1234) → unlocked=1, state=2, fail_cnt=0 one cycle after the 4th rise.
- Enter 4,3,2,0 → fail_pulse single cycle, fail_cnt=1, state=0. Repeat twice → state=3, alarm_led toggles every 256 cycles. Cancel → state=0, fail_cnt=0.
- Unlock, set_btn, enter 9,9,9,9 → state=0. Code 4,3,2,1 now fails. Code 9,9,9,9 unlocks.
- In SET_ENTRY after 2 digits, assert rst_n=0 → all outputs 0, code 4,3,2,1 unlocks. Also in SET_ENTRY, cancel → old code kept.
- Hold enter high for 20 cycles → entry_idx=1 only. cancel+enter rising in the same cycle during ENTRY → state=0, entry_idx=0.
- LOCKOUT_EN, LOCKOUT_CYCLES=1024: three failures → state=5. Cancel ignored. Returns to state=0 exactly 1024 cycles later.
